// File: rtl/peripheral_wb_pkg.sv
// rtl/peripheral_wb_pkg.sv - shared types and limits for the UART Wishbone bridge
// Contents: bridge FSM state enum, legal Wishbone data widths, read latency ceiling.
package peripheral_wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    WAIT,
    RESP,
    RECOVER
  } uart_bridge_state_t;

  localparam int DW_NARROW      = 8;
  localparam int DW_WIDE        = 32;
  localparam int RD_LATENCY_MAX = 7;

endpackage

// File: rtl/peripheral_uart_bridge_wb_gen_if.sv
// rtl/peripheral_uart_bridge_wb_gen_if.sv - Wishbone classic slave bus bundle
// Signals: wb_cyc_i/wb_stb_i/wb_we_i cycle controls, wb_sel_i byte select,
// wb_adr_i byte address, wb_dat_i write data, wb_dat_o read data,
// wb_ack_o/wb_err_o terminations. master drives requests, slave answers.
interface peripheral_uart_bridge_wb_gen_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic            wb_we_i;
  logic [DW/8-1:0] wb_sel_i;
  logic [AW-1:0]   wb_adr_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW-1:0]   wb_dat_o;
  logic            wb_ack_o;
  logic            wb_err_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/peripheral_uart_bridge_lane_wb.sv
// rtl/peripheral_uart_bridge_lane_wb.sv - combinational byte-lane decode and read-byte placement
// Inputs: adr/sel/dat (sampled bus request), lane_l (latched lane), rdata (register byte).
// Outputs: idx (register index), lane, bad (range or lane/sel error), wbyte, placed (rdata in lane_l).
module peripheral_uart_bridge_lane_wb
  import peripheral_wb_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AW       = 3,
  parameter int NUM_REGS = 8,
  parameter int RAW      = $clog2(NUM_REGS),
  parameter int LW       = (DW == DW_WIDE) ? 2 : 1
) (
  input  logic [AW-1:0]   adr,
  input  logic [DW/8-1:0] sel,
  input  logic [DW-1:0]   dat,
  input  logic [LW-1:0]   lane_l,
  input  logic [7:0]      rdata,
  output logic [RAW-1:0]  idx,
  output logic [LW-1:0]   lane,
  output logic            bad,
  output logic [7:0]      wbyte,
  output logic [DW-1:0]   placed
);
  localparam int SW = DW / 8;

  logic sel_bad;

  // The byte address is the register index; the low bits double as the lane.
  assign idx = adr[RAW-1:0];
  assign bad = (int'(adr) >= NUM_REGS) || sel_bad;

  generate
    if (DW == DW_WIDE) begin : g_wide
      assign lane    = adr[LW-1:0];
      // Exactly the one byte lane addressed must be selected.
      assign sel_bad = (sel != (SW'(1) << lane));
      assign wbyte   = dat[{lane, 3'b000} +: 8];
      assign placed  = DW'(rdata) << {lane_l, 3'b000};
    end else begin : g_narrow
      logic unused_narrow;
      assign unused_narrow = ^{sel, lane_l};
      assign lane    = '0;
      assign sel_bad = 1'b0;
      assign wbyte   = dat[7:0];
      assign placed  = DW'(rdata);
    end
  endgenerate

endmodule

// File: rtl/peripheral_uart_bridge_wb_gen.sv
// rtl/peripheral_uart_bridge_wb_gen.sv - Wishbone classic slave to UART byte register bridge
// Ports: clk, wb_rst_i (async active-high), wb (Wishbone slave bundle),
// reg_adr_o/reg_wdata_o/reg_rdata_i register side, reg_we_o/reg_re_o
// one-cycle strobes, busy_o high whenever the FSM is not idle.
module peripheral_uart_bridge_wb_gen
  import peripheral_wb_pkg::*;
#(
  parameter int DW         = DW_NARROW,
  parameter int AW         = 3,
  parameter int NUM_REGS   = 8,
  parameter int RD_LATENCY = 1,
  parameter int RAW        = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           wb_rst_i,
  peripheral_uart_bridge_wb_gen_if.slave wb,
  output logic [RAW-1:0]                 reg_adr_o,
  output logic [7:0]                     reg_wdata_o,
  input  logic [7:0]                     reg_rdata_i,
  output logic                           reg_we_o,
  output logic                           reg_re_o,
  output logic                           busy_o
);
  localparam int SW = DW / 8;
  localparam int LW = (DW == DW_WIDE) ? 2 : 1;
  localparam int CW = $clog2(RD_LATENCY_MAX + 1);

  // Registered copies of the bus inputs; the FSM only looks at these.
  logic          cyc_s, stb_s, we_s;
  logic [SW-1:0] sel_s;
  logic [AW-1:0] adr_s;
  logic [DW-1:0] dat_s;

  uart_bridge_state_t state, state_n;
  logic [CW-1:0]      cnt, cnt_n;

  logic [RAW-1:0] idx;
  logic [LW-1:0]  lane, lane_l;
  logic           bad;
  logic [7:0]     wbyte;
  logic [DW-1:0]  placed, dat_q;
  logic           we_l, err_l, abort_l;
  logic           accept, capture, ack, err, we_o, re_o;

  peripheral_uart_bridge_lane_wb #(
    .DW(DW), .AW(AW), .NUM_REGS(NUM_REGS), .RAW(RAW), .LW(LW)
  ) u_lane (
    .adr(adr_s), .sel(sel_s), .dat(dat_s), .lane_l(lane_l), .rdata(reg_rdata_i),
    .idx(idx), .lane(lane), .bad(bad), .wbyte(wbyte), .placed(placed)
  );

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cyc_s       <= 1'b0;
      stb_s       <= 1'b0;
      we_s        <= 1'b0;
      sel_s       <= '0;
      adr_s       <= '0;
      dat_s       <= '0;
      state       <= IDLE;
      cnt         <= '0;
      reg_adr_o   <= '0;
      reg_wdata_o <= '0;
      lane_l      <= '0;
      we_l        <= 1'b0;
      err_l       <= 1'b0;
      abort_l     <= 1'b0;
      dat_q       <= '0;
    end else begin
      cyc_s <= wb.wb_cyc_i;
      stb_s <= wb.wb_stb_i;
      we_s  <= wb.wb_we_i;
      sel_s <= wb.wb_sel_i;
      adr_s <= wb.wb_adr_i;
      dat_s <= wb.wb_dat_i;
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        reg_adr_o   <= idx;
        lane_l      <= lane;
        we_l        <= we_s;
        reg_wdata_o <= wbyte;
        err_l       <= bad;
        abort_l     <= 1'b0;
      end else if ((state == STROBE || state == WAIT) && !cyc_s) begin
        // Master gave up: finish the register access but stay silent in RESP.
        abort_l <= 1'b1;
      end
      if (capture) dat_q <= placed;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    capture = 1'b0;
    we_o    = 1'b0;
    re_o    = 1'b0;
    ack     = 1'b0;
    err     = 1'b0;
    case (state)
      IDLE: begin
        if (cyc_s && stb_s) begin
          accept  = 1'b1;
          state_n = bad ? RESP : STROBE;
        end
      end
      STROBE: begin
        we_o  = we_l;
        re_o  = ~we_l;
        cnt_n = CW'(RD_LATENCY);
        if (RD_LATENCY == 0) begin
          state_n = RESP;
          capture = ~we_l;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = RESP;
          capture = ~we_l;
        end
      end
      RESP: begin
        ack     = ~abort_l & ~err_l;
        err     = ~abort_l & err_l;
        state_n = RECOVER;
      end
      RECOVER: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign reg_we_o    = we_o;
  assign reg_re_o    = re_o;
  assign busy_o      = (state != IDLE);
  assign wb.wb_ack_o = ack;
  assign wb.wb_err_o = err;
  assign wb.wb_dat_o = dat_q;

endmodule

// File: tb/tb_peripheral_uart_bridge_wb_gen.sv
// tb/tb_peripheral_uart_bridge_wb_gen.sv - scoreboard bench for three bridge configurations
// u0: DW=8 RD_LATENCY=1, u1: DW=32 RD_LATENCY=3, u2: DW=8 RD_LATENCY=0; each with a small register model.
module tb_peripheral_uart_bridge_wb_gen;

  logic clk;
  logic rst;
  int   cyc_cnt = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  logic [2:0]       cyc_d, stb_d, we_d;
  logic [2:0][3:0]  adr_d, sel_d;
  logic [2:0][31:0] dat_d;

  logic [2:0]       ack_m, err_m, we_m, re_m, busy_m;
  logic [2:0][31:0] dato_m;
  logic [2:0][2:0]  radr_m;
  logic [2:0][7:0]  wdata_m, rdata_m;
  logic [2:0][2:0]  since_re;
  logic [7:0]       mem [3][8];

  typedef struct { int inst; bit err; logic [31:0] data; bit rd; int cyc; } term_t;
  typedef struct { int inst; bit we; logic [2:0] adr; logic [7:0] wdata; int cyc; } strb_t;
  term_t tq[$];
  strb_t sq[$];

  function automatic int rl_of(input int k);
    case (k)
      0: return 1;
      1: return 3;
      default: return 0;
    endcase
  endfunction

  peripheral_uart_bridge_wb_gen_if #(.DW(8),  .AW(4)) if0();
  peripheral_uart_bridge_wb_gen_if #(.DW(32), .AW(4)) if1();
  peripheral_uart_bridge_wb_gen_if #(.DW(8),  .AW(4)) if2();

  assign if0.wb_cyc_i = cyc_d[0];
  assign if0.wb_stb_i = stb_d[0];
  assign if0.wb_we_i  = we_d[0];
  assign if0.wb_sel_i = sel_d[0][0];
  assign if0.wb_adr_i = adr_d[0];
  assign if0.wb_dat_i = dat_d[0][7:0];
  assign ack_m[0]     = if0.wb_ack_o;
  assign err_m[0]     = if0.wb_err_o;
  assign dato_m[0]    = {24'h0, if0.wb_dat_o};

  assign if1.wb_cyc_i = cyc_d[1];
  assign if1.wb_stb_i = stb_d[1];
  assign if1.wb_we_i  = we_d[1];
  assign if1.wb_sel_i = sel_d[1];
  assign if1.wb_adr_i = adr_d[1];
  assign if1.wb_dat_i = dat_d[1];
  assign ack_m[1]     = if1.wb_ack_o;
  assign err_m[1]     = if1.wb_err_o;
  assign dato_m[1]    = if1.wb_dat_o;

  assign if2.wb_cyc_i = cyc_d[2];
  assign if2.wb_stb_i = stb_d[2];
  assign if2.wb_we_i  = we_d[2];
  assign if2.wb_sel_i = sel_d[2][0];
  assign if2.wb_adr_i = adr_d[2];
  assign if2.wb_dat_i = dat_d[2][7:0];
  assign ack_m[2]     = if2.wb_ack_o;
  assign err_m[2]     = if2.wb_err_o;
  assign dato_m[2]    = {24'h0, if2.wb_dat_o};

  peripheral_uart_bridge_wb_gen #(.DW(8), .AW(4), .NUM_REGS(8), .RD_LATENCY(1)) u0 (
    .clk(clk), .wb_rst_i(rst), .wb(if0),
    .reg_adr_o(radr_m[0]), .reg_wdata_o(wdata_m[0]), .reg_rdata_i(rdata_m[0]),
    .reg_we_o(we_m[0]), .reg_re_o(re_m[0]), .busy_o(busy_m[0])
  );

  peripheral_uart_bridge_wb_gen #(.DW(32), .AW(4), .NUM_REGS(8), .RD_LATENCY(3)) u1 (
    .clk(clk), .wb_rst_i(rst), .wb(if1),
    .reg_adr_o(radr_m[1]), .reg_wdata_o(wdata_m[1]), .reg_rdata_i(rdata_m[1]),
    .reg_we_o(we_m[1]), .reg_re_o(re_m[1]), .busy_o(busy_m[1])
  );

  peripheral_uart_bridge_wb_gen #(.DW(8), .AW(4), .NUM_REGS(8), .RD_LATENCY(0)) u2 (
    .clk(clk), .wb_rst_i(rst), .wb(if2),
    .reg_adr_o(radr_m[2]), .reg_wdata_o(wdata_m[2]), .reg_rdata_i(rdata_m[2]),
    .reg_we_o(we_m[2]), .reg_re_o(re_m[2]), .busy_o(busy_m[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register model: read data is valid only in the cycle the bridge must capture it.
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    for (int k = 0; k < 3; k++) begin
      if (rst) since_re[k] <= 3'd7;
      else if (re_m[k]) since_re[k] <= 3'd0;
      else if (since_re[k] != 3'd7) since_re[k] <= since_re[k] + 3'd1;
      if (rst) begin
        for (int i = 0; i < 8; i++) mem[k][i] <= 8'hA2 + 8'(16 * k + i);
      end else if (we_m[k]) begin
        mem[k][radr_m[k]] <= wdata_m[k];
      end
    end
  end

  always_comb begin
    rdata_m = '0;
    for (int k = 0; k < 3; k++) begin
      if ((rl_of(k) == 0) ? re_m[k] : (since_re[k] == 3'(rl_of(k) - 1)))
        rdata_m[k] = mem[k][radr_m[k]];
      else
        rdata_m[k] = 8'hEE;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every termination and every strobe must match the head of its queue.
  always @(negedge clk) begin
    term_t t;
    strb_t s;
    for (int k = 0; k < 3; k++) begin
      if (ack_m[k] || err_m[k]) begin
        if (tq.size() == 0) begin
          check($sformatf("unexpected_term_u%0d", k), 64'(1), 64'(0));
        end else begin
          t = tq.pop_front();
          check($sformatf("term_inst_u%0d", k), 64'(k), 64'(t.inst));
          check($sformatf("term_cycle_u%0d", k), 64'(cyc_cnt), 64'(t.cyc));
          check($sformatf("term_kind_u%0d", k), 64'({ack_m[k], err_m[k]}), 64'({~t.err, t.err}));
          if (t.rd) check($sformatf("rd_data_u%0d", k), 64'(dato_m[k]), 64'(t.data));
        end
      end
      if (we_m[k] || re_m[k]) begin
        if (sq.size() == 0) begin
          check($sformatf("unexpected_strobe_u%0d", k), 64'(1), 64'(0));
        end else begin
          s = sq.pop_front();
          check($sformatf("strobe_inst_u%0d", k), 64'(k), 64'(s.inst));
          check($sformatf("strobe_cycle_u%0d", k), 64'(cyc_cnt), 64'(s.cyc));
          check($sformatf("strobe_kind_u%0d", k), 64'({we_m[k], re_m[k]}), 64'({s.we, ~s.we}));
          check($sformatf("strobe_adr_u%0d", k), 64'(radr_m[k]), 64'(s.adr));
          if (s.we) check($sformatf("strobe_wdata_u%0d", k), 64'(wdata_m[k]), 64'(s.wdata));
        end
      end
    end
  end

  // Called at a falling edge; the next rising edge is E1.
  task automatic issue(input int k, input bit w, input logic [3:0] a, input logic [3:0] s,
                       input logic [31:0] d, input bit bad, input logic [7:0] wbyte,
                       output int c);
    c = cyc_cnt;
    if (!bad) sq.push_back('{k, w, a[2:0], wbyte, c + 2});
    we_d[k]  = w;
    adr_d[k] = a;
    sel_d[k] = s;
    dat_d[k] = d;
    cyc_d[k] = 1'b1;
    stb_d[k] = 1'b1;
  endtask

  task automatic xfer(input int k, input bit w, input logic [3:0] a, input logic [3:0] s,
                      input logic [31:0] d, input bit bad, input logic [7:0] wbyte,
                      input logic [31:0] rd);
    int c;
    bit done;
    issue(k, w, a, s, d, bad, wbyte, c);
    tq.push_back('{k, bad, rd, !w && !bad, c + (bad ? 2 : 3 + rl_of(k))});
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (ack_m[k] || err_m[k]) done = 1'b1;
    end
    if (!done) check($sformatf("term_timeout_u%0d", k), 64'(0), 64'(1));
    cyc_d[k] = 1'b0;
    stb_d[k] = 1'b0;
    we_d[k]  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst   = 1'b1;
    cyc_d = '0;
    stb_d = '0;
    we_d  = '0;
    adr_d = '0;
    sel_d = '0;
    dat_d = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("reset_outputs_u%0d", k),
            64'({busy_m[k], ack_m[k], err_m[k], re_m[k], we_m[k], radr_m[k], wdata_m[k], dato_m[k]}),
            64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // DW=8, latency 1
    xfer(0, 1'b0, 4'd3,  4'b0001, 32'h0,          1'b0, 8'h00, 32'h0000_00A5);
    xfer(0, 1'b1, 4'd2,  4'b0001, 32'h0000_005A,  1'b0, 8'h5A, 32'h0);
    xfer(0, 1'b0, 4'd2,  4'b0001, 32'h0,          1'b0, 8'h00, 32'h0000_005A);
    xfer(0, 1'b0, 4'd9,  4'b0001, 32'h0,          1'b1, 8'h00, 32'h0);
    xfer(0, 1'b1, 4'd15, 4'b0001, 32'h0000_0033,  1'b1, 8'h00, 32'h0);

    // DW=32, latency 3: lane steering and lane/sel/range errors
    xfer(1, 1'b1, 4'd6,  4'b0100, 32'h11C3_2233,  1'b0, 8'hC3, 32'h0);
    xfer(1, 1'b0, 4'd6,  4'b0100, 32'h0,          1'b0, 8'h00, 32'h00C3_0000);
    xfer(1, 1'b0, 4'd1,  4'b0010, 32'h0,          1'b0, 8'h00, 32'h0000_B300);
    xfer(1, 1'b0, 4'd3,  4'b1000, 32'h0,          1'b0, 8'h00, 32'hB500_0000);
    xfer(1, 1'b0, 4'd4,  4'b0001, 32'h0,          1'b0, 8'h00, 32'h0000_00B6);
    xfer(1, 1'b0, 4'd5,  4'b0001, 32'h0,          1'b1, 8'h00, 32'h0);
    xfer(1, 1'b1, 4'd5,  4'b0011, 32'hFFFF_FFFF,  1'b1, 8'h00, 32'h0);
    xfer(1, 1'b0, 4'd8,  4'b0001, 32'h0,          1'b1, 8'h00, 32'h0);

    // DW=8, latency 0
    xfer(2, 1'b0, 4'd7,  4'b0001, 32'h0,          1'b0, 8'h00, 32'h0000_00C9);
    xfer(2, 1'b1, 4'd0,  4'b0001, 32'h0000_0077,  1'b0, 8'h77, 32'h0);
    xfer(2, 1'b0, 4'd0,  4'b0001, 32'h0,          1'b0, 8'h00, 32'h0000_0077);

    // Abort: drop cyc while u1 is in WAIT; strobe happens, no termination.
    issue(1, 1'b0, 4'd2, 4'b0100, 32'h0, 1'b0, 8'h00, c);
    repeat (3) @(negedge clk);
    cyc_d[1] = 1'b0;
    stb_d[1] = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_back_to_idle", 64'(busy_m[1]), 64'(0));

    // Reset in the middle of WAIT: everything clears at once, no later strobe.
    issue(1, 1'b0, 4'd1, 4'b0010, 32'h0, 1'b0, 8'h00, c);
    repeat (4) @(negedge clk);
    check("pre_reset_busy", 64'(busy_m[1]), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs_u1",
          64'({busy_m[1], ack_m[1], err_m[1], re_m[1], we_m[1], radr_m[1], wdata_m[1], dato_m[1]}),
          64'(0));
    cyc_d[1] = 1'b0;
    stb_d[1] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_reset_idle", 64'(busy_m), 64'(0));

    check("term_queue_drained", 64'(tq.size()), 64'(0));
    check("strobe_queue_drained", 64'(sq.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
